systolic_mxu: RTL and testbench
===============================

// Module: systolic_mxu
// PURPOSE
//  Weight-stationary ROWS x COLS systolic matrix unit; next generation of the square PE array.
//  Loads a weight matrix row by row, then streams activation vectors with valid/ready handshakes.
//  Skews inputs and deskews outputs internally, so one COLS-wide dot-product vector leaves per accepted input vector.
//  Supports signed or unsigned arithmetic and saturating or wrapping accumulation.
// PARAMETERS
//  ROWS        4   PE rows = activation vector length = weight rows
//  COLS        4   PE columns = output vector length
//  DATA_WIDTH  4   activation/weight element width
//  ACC_WIDTH   16  partial-sum/result width (>= 2*DATA_WIDTH)
//  SIGNED      1   1: two's-complement operands/results; 0: unsigned
//  SATURATE    1   1: clamp every PE add to ACC range; 0: wrap modulo 2^ACC_WIDTH
// PORTS
//  clk      in   1                      clock
//  rst      in   1                      asynchronous, active-low reset
//  w_valid  in   1                      weight row beat valid
//  w_ready  out  1                      weight row beat accepted when w_valid&w_ready
//  w_data   in   [COLS][DATA_WIDTH]     one weight row; element c -> PE(row,c)
//  a_valid  in   1                      activation vector valid
//  a_ready  out  1                      activation vector accepted when a_valid&a_ready
//  a_data   in   [ROWS][DATA_WIDTH]     element r feeds row r
//  a_last   in   1                      marks last vector of a batch
//  y_valid  out  1                      result vector valid (single cycle, no backpressure)
//  y_data   out  [COLS][ACC_WIDTH]      y[c] = sum_r a[r]*W[r][c]
//  y_last   out  1                      a_last delayed alongside its vector
// BEHAVIOUR
//  Clocking: one clock; reset is asynchronous and active-low.
//  Reset (any time, including mid-operation): state=EMPTY, weights=0, skew/deskew/valid pipes cleared, inflight=0.
//   Outputs during/after reset: y_valid=0, y_last=0, y_data=0, a_ready=0, w_ready=1.
//   In-flight vectors are discarded; no y_valid for them.
//  FSM states EMPTY, LOAD, READY, DRAIN; row counter wcnt (0..ROWS-1).
//   EMPTY: w_ready=1, a_ready=0. Accepted w beat -> write row 0, wcnt=1, go LOAD (READY if ROWS==1).
//   LOAD: w_ready=1, a_ready=0. Each accepted beat writes row wcnt.
//     The beat that writes row ROWS-1 -> READY, wcnt=0.
//   READY: a_ready = !w_valid (weights have priority). w_ready = (inflight==0).
//     w_valid && inflight==0: beat accepted as row 0 -> LOAD.
//     w_valid && inflight!=0: beat not accepted -> DRAIN.
//   DRAIN: a_ready=0, w_ready=0. When inflight==0 -> READY; the pending beat is accepted next cycle.
//  Weights never change while any vector is in flight; results always use the weights present at acceptance.
//  Datapath: input row r delayed r cycles (skew); activation hops one PE right per cycle.
//   Partial sum hops one PE down per cycle; row 0 partial-sum input = 0.
//   Column c deskewed by COLS-1-c cycles.
//  Latency: vector accepted in cycle t -> y_valid in cycle t+ROWS+COLS-1, all COLS results together.
//   Throughput: 1 vector/cycle.
//  inflight counter, width $clog2(ROWS+COLS): +1 on accept, -1 on y_valid; both in one cycle = unchanged.
//  Arithmetic: product is DATA_WIDTH*2 bits, sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_WIDTH.
//   Each PE computes psum_out = psum_in + product.
//   SATURATE=1 clamps each add: signed [-2^(ACC-1), 2^(ACC-1)-1]; unsigned [0, 2^ACC-1].
//   Clamping happens per PE stage, so intermediate saturation propagates.
//   SATURATE=0 wraps.
//  y_data holds its last value when y_valid=0; consumers must sample only on y_valid.
//  Bubbles (a_valid=0) propagate as y_valid=0 gaps with identical spacing.
// TESTING (ROWS=COLS=2, DATA_WIDTH=4, ACC_WIDTH=16, SIGNED=1, SATURATE=1 unless noted)
//  1 Load rows [1,2],[3,4]; send a=[1,1] at cycle t -> y=[4,6], y_valid only at t+3.
//  2 Back-to-back a=[1,1],[2,-1],[-8,-8], a_last on 3rd -> y=[4,6],[-1,0],[-32,-48] on consecutive cycles; y_last on 3rd only.
//  3 ROWS=COLS=4, ACC_WIDTH=8, all W=7, a=[7,7,7,7] -> y=127 each. a=-8s -> -128.
//    Same config with SATURATE=0 and a=7s -> -60.
//  4 Accept one vector, then assert w_valid next cycle -> DRAIN, w_ready/a_ready low until old result (old W) emitted.
//    Then reload completes and READY resumes.
//  5 SIGNED=0: all W=15, a=[15,15] -> y=[450,450].
//  6 Assert rst with 2 vectors in flight -> no y_valid, state EMPTY, a_ready=0, w_ready=1.
//    a_valid ignored until ROWS weight beats are reloaded.

Source files
------------

// File: rtl/systolic_mxu.sv
// Weight-stationary ROWS x COLS systolic matrix unit with internal input skew and output deskew.
// Weights load row by row; activation vectors stream one per cycle and produce one result vector each.
module systolic_mxu #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 16,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic [COLS*DATA_WIDTH-1:0]     w_data,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]     a_data,
  input  logic                           a_last,
  output logic                           y_valid,
  output logic [COLS*ACC_WIDTH-1:0]      y_data,
  output logic                           y_last
);

  localparam int LAT = ROWS + COLS - 1;
  localparam int CW  = $clog2(ROWS + COLS);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {EMPTY = 2'd0, LOAD = 2'd1, READY = 2'd2, DRAIN = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          wcnt_q, wcnt_d, widx_s;
  logic [CW-1:0]          infl_q, infl_d;
  logic                   a_acc_s;
  logic [DATA_WIDTH-1:0]  w_q   [ROWS][COLS];
  logic [DATA_WIDTH-1:0]  sk_q  [ROWS][ROWS];
  logic [DATA_WIDTH-1:0]  ah_q  [ROWS][COLS];
  logic [ACC_WIDTH-1:0]   p_q   [ROWS][COLS];
  logic [ACC_WIDTH-1:0]   ds_q  [COLS][COLS];
  logic [DATA_WIDTH-1:0]  ain_s [ROWS][COLS];
  logic [ACC_WIDTH-1:0]   pin_s [ROWS][COLS];
  logic [ACC_WIDTH-1:0]   sum_s [ROWS][COLS];
  logic [ACC_WIDTH-1:0]   yin_s [COLS];
  logic [LAT-1:0]         vp_q, vp_d, lp_q, lp_d;
  logic [COLS*ACC_WIDTH-1:0] y_q;

  // One PE stage: psum_in + a*w, extended per signedness, clamped or wrapped.
  function automatic logic [ACC_WIDTH-1:0] pe_add(input logic [ACC_WIDTH-1:0] p,
                                                  input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] w);
    logic [2*DATA_WIDTH-1:0] xa, xw, prod;
    logic [ACC_WIDTH:0]      s;
    if (SIGNED != 0) begin
      xa   = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
      xw   = {{DATA_WIDTH{w[DATA_WIDTH-1]}}, w};
      prod = xa * xw;
      s    = {p[ACC_WIDTH-1], p} + {{(ACC_WIDTH+1-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
      if ((SATURATE != 0) && (s[ACC_WIDTH] != s[ACC_WIDTH-1])) begin
        return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        return s[ACC_WIDTH-1:0];
      end
    end else begin
      xa   = {{DATA_WIDTH{1'b0}}, a};
      xw   = {{DATA_WIDTH{1'b0}}, w};
      prod = xa * xw;
      s    = {1'b0, p} + {{(ACC_WIDTH+1-2*DATA_WIDTH){1'b0}}, prod};
      if ((SATURATE != 0) && s[ACC_WIDTH]) begin
        return {ACC_WIDTH{1'b1}};
      end else begin
        return s[ACC_WIDTH-1:0];
      end
    end
  endfunction

  assign a_acc_s = a_valid & a_ready;

  // Control FSM: handshakes, weight row index and next state.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    widx_s  = wcnt_q;
    w_ready = 1'b0;
    a_ready = 1'b0;
    case (state_q)
      EMPTY: begin
        w_ready = 1'b1;
        widx_s  = '0;
      end
      LOAD: begin
        w_ready = 1'b1;
      end
      READY: begin
        w_ready = (infl_q == '0);
        a_ready = ~w_valid;
        widx_s  = '0;
        if (w_valid && (infl_q != '0)) state_d = DRAIN;
        else                           state_d = READY;
      end
      DRAIN: begin
        if (infl_q == '0) state_d = READY;
        else              state_d = DRAIN;
      end
      default: begin
        state_d = EMPTY;
        wcnt_d  = '0;
      end
    endcase
    if (w_valid && w_ready) begin
      if (widx_s == RW'(ROWS - 1)) begin
        state_d = READY;
        wcnt_d  = '0;
      end else begin
        state_d = LOAD;
        wcnt_d  = widx_s + 1'b1;
      end
    end else begin
      wcnt_d = wcnt_d;
    end
    infl_d = infl_q + CW'(a_acc_s) - CW'(vp_q[LAT-1]);
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      wcnt_q  <= '0;
      infl_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      infl_q  <= infl_d;
    end
  end

  // Weight storage: only written while nothing is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) w_q[r][c] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (w_valid && w_ready && (widx_s == RW'(r))) w_q[r][c] <= w_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // PE inputs and sums; row 0 takes the accepted vector directly, row r via r skew stages.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (c == 0) ain_s[r][c] = (r == 0) ? a_data[DATA_WIDTH-1:0] : sk_q[r][(r == 0) ? 0 : r-1];
        else        ain_s[r][c] = ah_q[r][(c == 0) ? 0 : c-1];
        if (r == 0) pin_s[r][c] = '0;
        else        pin_s[r][c] = p_q[(r == 0) ? 0 : r-1][c];
        sum_s[r][c] = pe_add(pin_s[r][c], ain_s[r][c], w_q[r][c]);
      end
    end
    for (int c = 0; c < COLS; c++) begin
      if (c == COLS-1) yin_s[c] = sum_s[ROWS-1][c];
      else             yin_s[c] = ds_q[c][(c == COLS-1) ? 0 : COLS-2-c];
    end
  end

  // Skew, PE and deskew pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int k = 0; k < ROWS; k++) sk_q[r][k] <= '0;
        for (int c = 0; c < COLS; c++) begin
          ah_q[r][c] <= '0;
          p_q[r][c]  <= '0;
        end
      end
      for (int c = 0; c < COLS; c++)
        for (int k = 0; k < COLS; k++) ds_q[c][k] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int k = 0; k < ROWS; k++)
          sk_q[r][k] <= (k == 0) ? a_data[r*DATA_WIDTH +: DATA_WIDTH] : sk_q[r][(k == 0) ? 0 : k-1];
        for (int c = 0; c < COLS; c++) begin
          ah_q[r][c] <= ain_s[r][c];
          p_q[r][c]  <= sum_s[r][c];
        end
      end
      for (int c = 0; c < COLS; c++)
        for (int k = 0; k < COLS; k++)
          ds_q[c][k] <= (k == 0) ? sum_s[ROWS-1][c] : ds_q[c][(k == 0) ? 0 : k-1];
    end
  end

  // Valid/last shift chains aligned with the datapath latency.
  always_comb begin
    vp_d    = '0;
    lp_d    = '0;
    vp_d[0] = a_acc_s;
    lp_d[0] = a_acc_s & a_last;
    for (int i = 1; i < LAT; i++) begin
      vp_d[i] = vp_q[i-1];
      lp_d[i] = lp_q[i-1];
    end
  end

  // Output registers; y_data only updates with a valid result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vp_q <= '0;
      lp_q <= '0;
      y_q  <= '0;
    end else begin
      vp_q <= vp_d;
      lp_q <= lp_d;
      if (vp_d[LAT-1]) begin
        for (int c = 0; c < COLS; c++) y_q[c*ACC_WIDTH +: ACC_WIDTH] <= yin_s[c];
      end
    end
  end

  assign y_valid = vp_q[LAT-1];
  assign y_last  = lp_q[LAT-1];
  assign y_data  = y_q;

endmodule

// File: tb/tb_systolic_mxu.sv
// Scoreboard bench for systolic_mxu: 2x2 signed/unsigned pair and 4x4 8-bit saturating/wrapping pair.
module tb_systolic_mxu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t q_as[$], q_au[$], q_bs[$], q_bw[$];
  int last_a_cyc, last_w_cyc;

  // group A: 2x2, 4-bit data, 16-bit acc
  logic rst_a, wa_valid, aa_valid, aa_last;
  logic [7:0] wa_data, aa_data;
  logic as_w_ready, as_a_ready, as_y_valid, as_y_last;
  logic au_w_ready, au_a_ready, au_y_valid, au_y_last;
  logic [31:0] as_y_data, au_y_data;

  // group B: 4x4, 4-bit data, 8-bit acc
  logic rst_b, wb_valid, ab_valid, ab_last;
  logic [15:0] wb_data, ab_data;
  logic bs_w_ready, bs_a_ready, bs_y_valid, bs_y_last;
  logic bw_w_ready, bw_a_ready, bw_y_valid, bw_y_last;
  logic [31:0] bs_y_data, bw_y_data;

  systolic_mxu #(.ROWS(2), .COLS(2), .DATA_WIDTH(4), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(1)) u_as (
    .clk(clk), .rst(rst_a), .w_valid(wa_valid), .w_ready(as_w_ready), .w_data(wa_data),
    .a_valid(aa_valid), .a_ready(as_a_ready), .a_data(aa_data), .a_last(aa_last),
    .y_valid(as_y_valid), .y_data(as_y_data), .y_last(as_y_last));

  systolic_mxu #(.ROWS(2), .COLS(2), .DATA_WIDTH(4), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(1)) u_au (
    .clk(clk), .rst(rst_a), .w_valid(wa_valid), .w_ready(au_w_ready), .w_data(wa_data),
    .a_valid(aa_valid), .a_ready(au_a_ready), .a_data(aa_data), .a_last(aa_last),
    .y_valid(au_y_valid), .y_data(au_y_data), .y_last(au_y_last));

  systolic_mxu #(.ROWS(4), .COLS(4), .DATA_WIDTH(4), .ACC_WIDTH(8), .SIGNED(1), .SATURATE(1)) u_bs (
    .clk(clk), .rst(rst_b), .w_valid(wb_valid), .w_ready(bs_w_ready), .w_data(wb_data),
    .a_valid(ab_valid), .a_ready(bs_a_ready), .a_data(ab_data), .a_last(ab_last),
    .y_valid(bs_y_valid), .y_data(bs_y_data), .y_last(bs_y_last));

  systolic_mxu #(.ROWS(4), .COLS(4), .DATA_WIDTH(4), .ACC_WIDTH(8), .SIGNED(1), .SATURATE(0)) u_bw (
    .clk(clk), .rst(rst_b), .w_valid(wb_valid), .w_ready(bw_w_ready), .w_data(wb_data),
    .a_valid(ab_valid), .a_ready(bw_a_ready), .a_data(ab_data), .a_last(ab_last),
    .y_valid(bw_y_valid), .y_data(bw_y_data), .y_last(bw_y_last));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: y_valid with data %h at cycle %0d, expected no output", name, act, cyc);
  endtask

  // monitors: pop expected result whenever a DUT presents y_valid
  always @(negedge clk) begin
    exp_t e;
    if (as_y_valid === 1'b1) begin
      if (q_as.size() == 0) check_unexpected("as_unexpected", as_y_data);
      else begin
        e = q_as.pop_front();
        check("as_data", as_y_data, e.data);
        check("as_last", {31'd0, as_y_last}, {31'd0, e.last});
        check("as_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (au_y_valid === 1'b1) begin
      if (q_au.size() == 0) check_unexpected("au_unexpected", au_y_data);
      else begin
        e = q_au.pop_front();
        check("au_data", au_y_data, e.data);
        check("au_last", {31'd0, au_y_last}, {31'd0, e.last});
        check("au_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bs_y_valid === 1'b1) begin
      if (q_bs.size() == 0) check_unexpected("bs_unexpected", bs_y_data);
      else begin
        e = q_bs.pop_front();
        check("bs_data", bs_y_data, e.data);
        check("bs_last", {31'd0, bs_y_last}, {31'd0, e.last});
        check("bs_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bw_y_valid === 1'b1) begin
      if (q_bw.size() == 0) check_unexpected("bw_unexpected", bw_y_data);
      else begin
        e = q_bw.pop_front();
        check("bw_data", bw_y_data, e.data);
        check("bw_last", {31'd0, bw_y_last}, {31'd0, e.last});
        check("bw_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic a_wbeat(input logic [7:0] d);
    int n = 0;
    wa_valid = 1'b1;
    wa_data  = d;
    @(negedge clk);
    while (!as_w_ready && n < 40) begin n++; @(negedge clk); end
    check("a_wbeat_ready", {31'd0, as_w_ready}, 32'd1);
    last_w_cyc = cyc;
    @(posedge clk); #1;
    wa_valid = 1'b0;
  endtask

  task automatic a_vec(input logic [7:0] d, input logic l, input logic [31:0] es, input logic [31:0] eu);
    int n = 0;
    aa_valid = 1'b1;
    aa_data  = d;
    aa_last  = l;
    @(negedge clk);
    while (!as_a_ready && n < 40) begin n++; @(negedge clk); end
    check("a_vec_ready", {31'd0, as_a_ready}, 32'd1);
    last_a_cyc = cyc;
    q_as.push_back('{cyc + 3, es, l});
    q_au.push_back('{cyc + 3, eu, l});
    @(posedge clk); #1;
    aa_valid = 1'b0;
    aa_last  = 1'b0;
  endtask

  task automatic b_wbeat(input logic [15:0] d);
    int n = 0;
    wb_valid = 1'b1;
    wb_data  = d;
    @(negedge clk);
    while (!bs_w_ready && n < 40) begin n++; @(negedge clk); end
    check("b_wbeat_ready", {31'd0, bs_w_ready}, 32'd1);
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic b_vec(input logic [15:0] d, input logic l, input logic [31:0] es, input logic [31:0] ew);
    int n = 0;
    ab_valid = 1'b1;
    ab_data  = d;
    ab_last  = l;
    @(negedge clk);
    while (!bs_a_ready && n < 40) begin n++; @(negedge clk); end
    check("b_vec_ready", {31'd0, bs_a_ready}, 32'd1);
    q_bs.push_back('{cyc + 7, es, l});
    q_bw.push_back('{cyc + 7, ew, l});
    @(posedge clk); #1;
    ab_valid = 1'b0;
    ab_last  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b0; wa_valid = 1'b0; wa_data = 8'h00; aa_valid = 1'b0; aa_data = 8'h00; aa_last = 1'b0;
    rst_b = 1'b0; wb_valid = 1'b0; wb_data = 16'h0000; ab_valid = 1'b0; ab_data = 16'h0000; ab_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_w_ready", {31'd0, as_w_ready}, 32'd1);
    check("rst_a_ready", {31'd0, as_a_ready}, 32'd0);
    check("rst_y_valid", {31'd0, as_y_valid}, 32'd0);
    check("rst_y_last", {31'd0, as_y_last}, 32'd0);
    check("rst_y_data", as_y_data, 32'h0);
    check("rst_b_w_ready", {31'd0, bs_w_ready}, 32'd1);
    @(posedge clk); #1;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // W = [1,2],[3,4]; a = [1,1] -> [4,6] at t+3
    a_wbeat(8'h21);
    a_wbeat(8'h43);
    a_vec(8'h11, 1'b0, 32'h0006_0004, 32'h0006_0004);
    repeat (6) @(negedge clk);
    check("hold_y_data", as_y_data, 32'h0006_0004);
    check("hold_y_valid", {31'd0, as_y_valid}, 32'd0);
    @(posedge clk); #1;

    // back-to-back stream, last on third
    a_vec(8'h11, 1'b0, 32'h0006_0004, 32'h0006_0004);
    a_vec(8'hF2, 1'b0, 32'h0000_FFFF, 32'h0040_002F);
    a_vec(8'h88, 1'b1, 32'hFFD0_FFE0, 32'h0030_0020);
    repeat (6) @(posedge clk); #1;

    // weight request while a vector is in flight -> drain first
    a_vec(8'h11, 1'b0, 32'h0006_0004, 32'h0006_0004);
    wa_valid = 1'b1;
    wa_data  = 8'h02;
    aa_valid = 1'b1;
    aa_data  = 8'h11;
    @(negedge clk);
    check("drain_w_ready", {31'd0, as_w_ready}, 32'd0);
    check("drain_a_ready", {31'd0, as_a_ready}, 32'd0);
    @(negedge clk);
    check("drain2_w_ready", {31'd0, as_w_ready}, 32'd0);
    check("drain2_a_ready", {31'd0, as_a_ready}, 32'd0);
    aa_valid = 1'b0;
    a_wbeat(8'h02);
    check("drain_reload_cycle", 32'(last_w_cyc), 32'(last_a_cyc + 5));
    a_wbeat(8'h20);
    a_vec(8'hF3, 1'b0, 32'hFFFE_0006, 32'h001E_0006);
    repeat (6) @(posedge clk); #1;

    // all W = 15: unsigned 450, signed (-1 * -1) * 2 = 2
    a_wbeat(8'hFF);
    a_wbeat(8'hFF);
    a_vec(8'hFF, 1'b1, 32'h0002_0002, 32'h01C2_01C2);
    repeat (6) @(posedge clk); #1;

    // reset with two vectors in flight
    a_vec(8'h11, 1'b0, 32'hFFFE_FFFE, 32'h001E_001E);
    a_vec(8'h11, 1'b0, 32'hFFFE_FFFE, 32'h001E_001E);
    rst_a = 1'b0;
    q_as.delete();
    q_au.delete();
    @(negedge clk);
    check("mid_rst_y_valid", {31'd0, as_y_valid}, 32'd0);
    check("mid_rst_y_data", as_y_data, 32'h0);
    check("mid_rst_w_ready", {31'd0, as_w_ready}, 32'd1);
    check("mid_rst_a_ready", {31'd0, as_a_ready}, 32'd0);
    @(posedge clk); #1;
    rst_a    = 1'b1;
    aa_valid = 1'b1;
    aa_data  = 8'h32;
    repeat (6) @(negedge clk);
    check("post_rst_a_ready", {31'd0, as_a_ready}, 32'd0);
    check("post_rst_u_a_ready", {31'd0, au_a_ready}, 32'd0);
    @(posedge clk); #1;
    a_wbeat(8'h11);
    @(negedge clk);
    check("load_a_ready", {31'd0, as_a_ready}, 32'd0);
    @(posedge clk); #1;
    a_wbeat(8'h11);
    a_vec(8'h32, 1'b1, 32'h0005_0005, 32'h0005_0005);
    repeat (6) @(posedge clk); #1;

    // 4x4, 8-bit acc, all W = 7: per-stage clamp vs wrap
    repeat (4) b_wbeat(16'h7777);
    b_vec(16'h7777, 1'b0, 32'h7F7F_7F7F, 32'hC4C4_C4C4);
    b_vec(16'h8888, 1'b0, 32'h8080_8080, 32'h2020_2020);
    b_vec(16'h8777, 1'b0, 32'h4747_4747, 32'h5B5B_5B5B);
    b_vec(16'h7888, 1'b1, 32'hB1B1_B1B1, 32'h8989_8989);
    repeat (12) @(posedge clk);
    @(negedge clk);

    check("as_pending", 32'(q_as.size()), 32'd0);
    check("au_pending", 32'(q_au.size()), 32'd0);
    check("bs_pending", 32'(q_bs.size()), 32'd0);
    check("bw_pending", 32'(q_bw.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
